mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control unit for the RV32I processor core. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives all datapath strobes plus the 4-bit ALUCtrl. Unlike the fixed five-cycle control, it stalls on ready/valid memory handshakes and runs a per-state watchdog. A sticky TRAP state catches illegal opcodes and memory timeouts. It sits in top_proc beside the datapath and replaces the inline control logic.

Parameters:
TIMEOUT_CYCLES, 16, maximum wait cycles in IF or MEM before entering TRAP; legal range 1..255.
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter; derived, never overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
instr  in  32  instruction register contents from the datapath; stable from ID until the next IRWrite.
Zero  in  1  ALU zero flag; valid in EX.
imem_ready  in  1  instruction memory has valid data this cycle.
dmem_ready  in  1  data memory access completes this cycle.
imem_req  out  1  instruction fetch request.
IRWrite  out  1  load the instruction register.
PCWrite  out  1  update the PC.
PCSrc  out  1  0 = PC+4, 1 = branch target; meaningful only while PCWrite=1.
ALUSrc  out  1  0 = rs2, 1 = immediate.
ALUCtrl  out  4  ALU operation.
MemRead  out  1  data read strobe.
MemWrite  out  1  data write strobe.
MemToReg  out  1  write-back source: 1 = memory data, 0 = ALU result.
RegWrite  out  1  register file write enable.
trap  out  1  sticky error flag.
state_o  out  3  current state, for debug.

Behaviour:
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP on the next edge.
- Sequential elements: the state register and the wait counter only. All outputs are combinational from the state and instr fields.
- Reset (rst=0): state=IF, counter=0, every output forced to 0 (including imem_req). imem_req rises in the first cycle after rst releases.
- Reset asserted mid-instruction aborts it immediately. No strobe is held into reset.
- IF:
  - imem_req=1.
  - If imem_ready=1: IRWrite=1 for that cycle, then go to ID.
  - Otherwise stay in IF and increment the counter.
- ID:
  - Opcode 0110011, 0010011, 0000011, 0100011 or 1100011 goes to EX.
  - Any other opcode goes to TRAP.
- EX, R-type or I-ALU: go to WB. ALUSrc=1 for I-ALU.
- EX, load or store: ALUSrc=1, ALUCtrl=ADD, go to MEM.
- EX, branch:
  - ALUCtrl=SUB, PCWrite=1.
  - PCSrc=1 for beq with Zero=1, or bne (funct3 001) with Zero=0; PCSrc=0 otherwise.
  - Other branch funct3 values go to TRAP.
  - Otherwise go to IF.
- MEM:
  - MemRead=1 for a load, MemWrite=1 for a store; the strobe is held until dmem_ready=1.
  - Load on ready: go to WB.
  - Store on ready: PCWrite=1, PCSrc=0, go to IF.
- WB: RegWrite=1, PCWrite=1, PCSrc=0, MemToReg=1 for a load. Go to IF.
- Watchdog:
  - The counter clears on every state transition.
  - In IF or MEM, if the counter reaches TIMEOUT_CYCLES without ready, go to TRAP on that edge.
  - Ready arriving in the same cycle as the limit wins.
- TRAP: trap=1 and all strobes 0. Exit only by reset.
- ALUCtrl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLL=1000, SRL=1001, SRA=1010, XOR=1101.
- ALUCtrl decode from funct3, with funct7[5] qualifying:
  - funct7[5] selects SUB only for R-type funct3 000.
  - funct7[5] selects SRA for funct3 101 in both R and I forms.
  - funct3 011 and 010 both map to SLT.
- ALUCtrl outside EX: ADD.
- Latency: ALU instructions take 4 cycles, loads 5, stores 4, branches 3, each plus memory wait cycles.

Decomposition:
- Package mc_pkg holds:
  - state_t enum;
  - opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - alu_op_t with the encodings above.
- One sub-module, mc_alu_dec: combinational, taking opcode class, funct3 and funct7[5] and producing ALUCtrl. The datapath may reuse it.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with imem_ready=1 every cycle -> state_o sequence 0,1,2,4,0; RegWrite=1 only in cycle 4; ALUCtrl=0010 in EX.
- lw (0x0000A183) with dmem_ready delayed 3 cycles -> MemRead high for 4 cycles, then WB with MemToReg=1; total 8 cycles to the next IF.
- beq, Zero=1 -> EX has PCWrite=1 and PCSrc=1, then IF. Same with Zero=0 -> PCSrc=0.
- imem_ready held 0 with TIMEOUT_CYCLES=4 -> TRAP entered after 4 wait cycles; trap=1 persists until rst=0, then state_o=0.
- Opcode 0x7F in ID -> TRAP next cycle; all strobes 0.
- rst driven low mid-MEM with MemWrite=1 -> MemWrite drops in the same cycle (asynchronous); after release, state_o=0 and imem_req=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and the opcode classifier used by control and datapath.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_XOR = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_BAD    = 3'd5
  } op_class_t;

  // Anything outside the supported subset collapses to CLS_BAD and traps.
  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps opcode class, funct3 and funct7[5] to ALUCtrl.
// Purely combinational so the datapath can share it.
module mc_alu_dec
  import mc_pkg::*;
(
  input  op_class_t op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_op_t    alu_ctrl
);

  // funct7[5] means SUB only for register-register funct3 000; for shifts
  // right it picks SRA in both the R and I forms.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (op_class)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (op_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      CLS_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit with ready/valid memory stalls, a per-state
// wait watchdog and a sticky TRAP state left only through reset.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        trap,
  output logic [2:0]  state_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  op_class_t       op_class;
  alu_op_t         alu_dec;
  logic [2:0]      funct3;
  logic            wait_limit;
  logic            branch_ok;
  logic            branch_taken;
  logic            is_load;
  logic            is_store;
  logic            unused_instr;

  assign funct3       = instr[14:12];
  assign op_class     = classify(instr[6:0]);
  assign is_load      = (op_class == CLS_LOAD);
  assign is_store     = (op_class == CLS_STORE);
  assign wait_limit   = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign branch_taken = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
  assign state_o      = state;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  mc_alu_dec u_alu_dec (
    .op_class (op_class),
    .funct3   (funct3),
    .funct7b5 (instr[30]),
    .alu_ctrl (alu_dec)
  );

  // The wait counter holds cycles already spent waiting; hitting the limit
  // without ready traps on that edge, while ready in the same cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IF;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IF: begin
          if (imem_ready)      state <= S_ID;
          else if (wait_limit) state <= S_TRAP;
          else                 wait_cnt <= wait_cnt + 1'b1;
        end
        S_ID: begin
          state <= (op_class == CLS_BAD) ? S_TRAP : S_EX;
        end
        S_EX: begin
          case (op_class)
            CLS_R, CLS_I:        state <= S_WB;
            CLS_LOAD, CLS_STORE: state <= S_MEM;
            CLS_BRANCH:          state <= branch_ok ? S_IF : S_TRAP;
            default:             state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (!(is_load || is_store)) state <= S_TRAP;
          else if (dmem_ready)        state <= is_load ? S_WB : S_IF;
          else if (wait_limit)        state <= S_TRAP;
          else                        wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB:    state <= S_IF;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Outputs are gated by rst directly so an asserted reset kills every strobe
  // in the same cycle rather than waiting for the state register.
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    ALUCtrl  = 4'b0000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    trap     = 1'b0;
    if (rst) begin
      ALUCtrl = ALU_ADD;
      case (state)
        S_IF: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
        end
        S_EX: begin
          ALUCtrl = alu_dec;
          ALUSrc  = (op_class == CLS_I) || is_load || is_store;
          if (op_class == CLS_BRANCH && branch_ok) begin
            PCWrite = 1'b1;
            PCSrc   = branch_taken;
          end
        end
        S_MEM: begin
          MemRead  = is_load;
          MemWrite = is_store;
          PCWrite  = is_store && dmem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          MemToReg = is_load;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
